// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks a word-aligned PC through instruction memory
// and queues {pc, instr} pairs in a small FIFO for decode. A redirect flushes
// the FIFO and restarts fetch at the new target.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   imem_addr/imem_en  fetch address (word aligned) and request strobe
//   imem_data          instruction word, combinationally valid with imem_en
//   redirect_valid/pc  branch/jump redirect strobe and target
//   out_valid/ready    decode handshake for the head FIFO entry
//   out_instr/out_pc   head FIFO entry payload
//   fetch_count        words pushed since reset (wraps)
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] fetch_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   localparam logic [1:0] S_BOOT  = 2'b00;
   localparam logic [1:0] S_FETCH = 2'b01;
   localparam logic [1:0] S_FULL  = 2'b10;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [31:0]      fetch_pc;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [OCC_W-1:0] occ;
   logic [OCC_W-1:0] occ_nxt;
   logic [31:0]      instr_q [DEPTH];
   logic [31:0]      pc_q    [DEPTH];
   logic             push;
   logic             pop;

   // Request depends only on registered state and the redirect strobe, never on out_ready.
   assign imem_en   = !rst && (state == S_FETCH) && (occ < OCC_FULL) && !redirect_valid;
   assign imem_addr = fetch_pc;
   assign push      = imem_en;

   // Outputs forced to zero while in reset so stale entries never leak out.
   assign out_valid = !rst && (occ != '0);
   assign out_instr = out_valid ? instr_q[head] : 32'h0;
   assign out_pc    = out_valid ? pc_q[head]    : 32'h0;
   assign pop       = out_valid && out_ready;

   // Next occupancy; a redirect empties the FIFO regardless of push/pop.
   always_comb begin
      occ_nxt = occ;
      if (redirect_valid) begin
         occ_nxt = '0;
      end else if (push && !pop) begin
         occ_nxt = occ + OCC_W'(1);
      end else if (!push && pop) begin
         occ_nxt = occ - OCC_W'(1);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         state_nxt = S_FETCH;
      end else begin
         case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: if (occ_nxt == OCC_FULL) state_nxt = S_FULL;
            S_FULL:  if (occ_nxt < OCC_FULL)  state_nxt = S_FETCH;
            default: state_nxt = S_BOOT;
         endcase
      end
   end

   // State, pointers, PC and counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_BOOT;
         fetch_pc    <= RESET_PC_ALIGNED;
         head        <= '0;
         tail        <= '0;
         occ         <= '0;
         fetch_count <= 32'h0;
      end else begin
         state <= state_nxt;
         occ   <= occ_nxt;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'h3;
            head     <= '0;
            tail     <= '0;
         end else begin
            if (push) begin
               fetch_pc    <= fetch_pc + 32'd4;
               tail        <= tail + PTR_W'(1);
               fetch_count <= fetch_count + 32'd1;
            end
            if (pop) begin
               head <= head + PTR_W'(1);
            end
         end
      end
   end

   // FIFO storage; contents are qualified by occupancy so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[tail] <= imem_data;
         pc_q[tail]    <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_ready = 1'b0;

   logic [31:0] imem_addr, imem_data, out_instr, out_pc, fetch_count;
   logic        imem_en, out_valid;

   logic [31:0] w_imem_addr, w_imem_data, w_out_instr, w_out_pc, w_fetch_count;
   logic        w_imem_en, w_out_valid;
   logic        w_redirect_valid = 1'b0;
   logic [31:0] w_redirect_pc = 32'h0;
   logic        w_out_ready = 1'b1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Instruction memory contents.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_0033;
      if (a == 32'h4) return 32'h0010_0093;
      return {a[15:0], ~a[15:0]};
   endfunction

   assign imem_data   = word_at(imem_addr);
   assign w_imem_data = word_at(w_imem_addr);

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .fetch_count(fetch_count)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
      .clk(clk), .rst(rst),
      .imem_addr(w_imem_addr), .imem_en(w_imem_en), .imem_data(w_imem_data),
      .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
      .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_instr(w_out_instr), .out_pc(w_out_pc), .fetch_count(w_fetch_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: queue of {pc, instr}, checked then advanced each negedge.
   logic [63:0] mq[$];
   logic [31:0] mpc = 32'h0;
   bit          mboot = 1'b1;
   logic [31:0] mcount = 32'h0;

   always @(negedge clk) begin : model
      logic exp_en;
      logic exp_valid;
      exp_en    = !rst && !mboot && (mq.size() < DEPTH) && !redirect_valid;
      exp_valid = !rst && (mq.size() != 0);
      chk("m_imem_en", 32'(imem_en), 32'(exp_en));
      chk("m_imem_addr", imem_addr, mpc);
      chk("m_fetch_count", fetch_count, mcount);
      chk("m_out_valid", 32'(out_valid), 32'(exp_valid));
      if (rst) begin
         chk("m_rst_out_pc", out_pc, 32'h0);
         chk("m_rst_out_instr", out_instr, 32'h0);
      end else if (exp_valid) begin
         chk("m_out_pc", out_pc, mq[0][63:32]);
         chk("m_out_instr", out_instr, mq[0][31:0]);
      end
      if (rst) begin
         mq.delete();
         mpc    = 32'h0;
         mboot  = 1'b1;
         mcount = 32'h0;
      end else if (redirect_valid) begin
         mq.delete();
         mpc   = {redirect_pc[31:2], 2'b00};
         mboot = 1'b0;
      end else begin
         if (exp_valid && out_ready) void'(mq.pop_front());
         if (exp_en) begin
            mq.push_back({mpc, word_at(mpc)});
            mpc    = mpc + 32'd4;
            mcount = mcount + 32'd1;
         end
         mboot = 1'b0;
      end
   end

   // One clock cycle of stimulus; returns at the negedge for sampling.
   task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      @(posedge clk);
      #1;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      int delivered;
      logic [31:0] bp_pcs [5];
      bp_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

      // Boot sequence and wrap-around instance.
      cyc(1, 0, 32'h0, 1);
      cyc(1, 0, 32'h0, 1);
      cyc(0, 0, 32'h0, 1);
      chk("boot_en_low", 32'(imem_en), 32'h0);
      chk("boot_valid_low", 32'(out_valid), 32'h0);
      cyc(0, 0, 32'h0, 1);
      chk("boot_first_en", 32'(imem_en), 32'h1);
      chk("boot_first_addr", imem_addr, 32'h0);
      cyc(0, 0, 32'h0, 1);
      chk("boot_pc0", out_pc, 32'h0);
      chk("boot_instr0", out_instr, 32'h0000_0033);
      chk("wrap_pc0", w_out_pc, 32'hFFFF_FFF8);
      cyc(0, 0, 32'h0, 1);
      chk("boot_pc1", out_pc, 32'h4);
      chk("boot_instr1", out_instr, 32'h0010_0093);
      chk("wrap_pc1", w_out_pc, 32'hFFFF_FFFC);
      cyc(0, 0, 32'h0, 1);
      chk("wrap_pc2", w_out_pc, 32'h0000_0000);
      chk("wrap_valid2", 32'(w_out_valid), 32'h1);

      // Backpressure: 10 stalled cycles then drain.
      cyc(1, 0, 32'h0, 0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 32'h0, 0);
         if (imem_en) pulses++;
      end
      chk("bp_pulses", 32'(pulses), 32'd4);
      chk("bp_held_pc", out_pc, 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 32'h0, 1);
         chk("bp_valid", 32'(out_valid), 32'h1);
         chk("bp_pc", out_pc, bp_pcs[i]);
      end

      // Redirect with three entries buffered, then back-to-back redirects.
      cyc(1, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 0);
      cyc(0, 1, 32'h0000_0103, 1);
      chk("rd_en_suppressed", 32'(imem_en), 32'h0);
      chk("rd_valid_before", 32'(out_valid), 32'h1);
      cyc(0, 0, 32'h0, 0);
      chk("rd_flushed", 32'(out_valid), 32'h0);
      chk("rd_addr", imem_addr, 32'h0000_0100);
      cyc(0, 0, 32'h0, 0);
      chk("rd_out_pc", out_pc, 32'h0000_0100);
      chk("rd_out_instr", out_instr, 32'h0100_FEFF);
      cyc(0, 1, 32'h0000_0200, 0);
      cyc(0, 1, 32'h0000_0302, 0);
      cyc(0, 0, 32'h0, 0);
      chk("rd_b2b_addr", imem_addr, 32'h0000_0300);
      cyc(0, 0, 32'h0, 1);
      chk("rd_b2b_pc", out_pc, 32'h0000_0300);

      // Push and pop together at DEPTH-1, then reset mid-stream.
      cyc(1, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 32'h0, 1);
         chk("pp_en", 32'(imem_en), 32'h1);
         chk("pp_valid", 32'(out_valid), 32'h1);
      end
      cyc(0, 0, 32'h0, 0);
      chk("pp_still_three", 32'(imem_en), 32'h1);
      cyc(0, 0, 32'h0, 0);
      chk("pp_now_full", 32'(imem_en), 32'h0);
      cyc(1, 0, 32'h0, 1);
      chk("mr_en", 32'(imem_en), 32'h0);
      chk("mr_valid", 32'(out_valid), 32'h0);
      chk("mr_pc", out_pc, 32'h0);
      chk("mr_instr", out_instr, 32'h0);
      cyc(0, 0, 32'h0, 1);
      chk("mr_addr", imem_addr, 32'h0);
      chk("mr_count", fetch_count, 32'h0);
      chk("mr_valid_after", 32'(out_valid), 32'h0);

      // fetch_count: 2 flushed by redirect + 18 delivered.
      cyc(1, 0, 32'h0, 0);
      cyc(0, 0, 32'h0, 0);
      cyc(0, 0, 32'h0, 0);
      cyc(0, 0, 32'h0, 0);
      cyc(0, 1, 32'h0000_0400, 1);
      chk("fc_two", fetch_count, 32'd2);
      delivered = 0;
      for (int i = 1; i <= 22; i++) begin
         cyc(0, 0, 32'h0, 1);
         if (out_valid && out_pc >= 32'h400 && out_pc <= 32'h444) delivered++;
         if (i == 19) chk("fc_twenty", fetch_count, 32'd20);
      end
      chk("fc_delivered", 32'(delivered), 32'd18);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
